// File: rtl/meter_pkg.sv
// Shared constants, state type and BCD helper for the parking-meter controller.
// The BCD helper is only used when METER_BCD_OUT_EN is defined.
package meter_pkg;

  localparam int MAX_COUNT  = 9999;
  localparam int LOW_THRESH = 200;

  localparam int ADD_50  = 50;
  localparam int ADD_150 = 150;
  localparam int ADD_200 = 200;
  localparam int ADD_500 = 500;

  localparam int PRESET_10  = 10;
  localparam int PRESET_205 = 205;

  typedef enum logic [1:0] {
    EXPIRED = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2
  } meter_state_t;

  // Shift-and-add-3 conversion of a 14-bit value (0..9999) into four BCD digits.
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sr;
    sr = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[14+4*d +: 4] >= 4'd5) begin
          sr[14+4*d +: 4] = sr[14+4*d +: 4] + 4'd3;
        end
      end
      sr = sr << 1;
    end
    return sr[29:14];
  endfunction

endpackage

// File: rtl/meter_tick_gen.sv
// Free-running half-second divider with a phase bit; emits a half-second pulse
// and a one-second tick on every second half pulse (phase 1 -> 0).
module meter_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic half_pulse,
  output logic tick_1hz
);

  localparam int HALF  = (CLK_HZ / 2 < 1) ? 1 : CLK_HZ / 2;
  localparam int DIV_W = ($clog2(HALF) < 1) ? 1 : $clog2(HALF);

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             r_half;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_W'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_half  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_div  <= w_wrap ? '0 : r_div + 1'b1;
      r_half <= w_wrap;
      r_tick <= w_wrap & r_phase;
      if (w_wrap) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign half_pulse = r_half;
  assign tick_1hz   = r_tick;

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter countdown controller: coin adds, presets, 1 Hz decrement,
// state tracking and display flash control. METER_BCD_OUT_EN adds a BCD output.
module meter_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int CNT_W      = 14,
  parameter int MAX_COUNT  = meter_pkg::MAX_COUNT,
  parameter int LOW_THRESH = meter_pkg::LOW_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_50,
  input  logic             add_150,
  input  logic             add_200,
  input  logic             add_500,
  input  logic             set_10,
  input  logic             set_205,
  output logic [CNT_W-1:0] BCOUNT,
  output logic             tick_1hz,
  output logic             blank,
  output logic [1:0]       state_o
`ifdef METER_BCD_OUT_EN
  ,
  output logic [15:0]      bcd_o
`endif
);

  import meter_pkg::meter_state_t;
  import meter_pkg::EXPIRED;
  import meter_pkg::LOW;
  import meter_pkg::HIGH;
  import meter_pkg::ADD_50;
  import meter_pkg::ADD_150;
  import meter_pkg::ADD_200;
  import meter_pkg::ADD_500;
  import meter_pkg::PRESET_10;
  import meter_pkg::PRESET_205;

  localparam int SUM_W = CNT_W + 1;

  logic             w_half;
  logic             w_tick;

  logic [CNT_W-1:0] r_count;
  meter_state_t     r_state;
  logic             r_blank;

  logic [SUM_W-1:0] w_amt;
  logic [SUM_W-1:0] w_sum;
  logic             w_any_add;
  logic             w_dec;
  logic [CNT_W-1:0] w_next;
  meter_state_t     w_next_state;
  logic             w_next_blank;

  meter_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .half_pulse(w_half),
    .tick_1hz  (w_tick)
  );

  // Only the largest coin pressed in a cycle is credited.
  always_comb begin
    w_amt = '0;
    if (add_500) begin
      w_amt = SUM_W'(ADD_500);
    end else if (add_200) begin
      w_amt = SUM_W'(ADD_200);
    end else if (add_150) begin
      w_amt = SUM_W'(ADD_150);
    end else if (add_50) begin
      w_amt = SUM_W'(ADD_50);
    end
  end

  assign w_any_add = add_500 | add_200 | add_150 | add_50;
  assign w_dec     = w_tick & (r_count != '0);
  assign w_sum     = {1'b0, r_count} + w_amt - {{CNT_W{1'b0}}, w_dec};

  always_comb begin
    w_next = r_count;
    if (set_205) begin
      w_next = CNT_W'(PRESET_205);
    end else if (set_10) begin
      w_next = CNT_W'(PRESET_10);
    end else if (w_any_add) begin
      w_next = (w_sum > SUM_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : w_sum[CNT_W-1:0];
    end else begin
      w_next = r_count - {{(CNT_W-1){1'b0}}, w_dec};
    end
  end

  always_comb begin
    w_next_state = HIGH;
    if (w_next == '0) begin
      w_next_state = EXPIRED;
    end else if (w_next < CNT_W'(LOW_THRESH)) begin
      w_next_state = LOW;
    end
  end

  // Entering a new state always restarts the flash with the display on.
  always_comb begin
    w_next_blank = 1'b0;
    if (w_next_state == r_state) begin
      case (r_state)
        LOW:     w_next_blank = r_blank ^ w_tick;
        EXPIRED: w_next_blank = r_blank ^ w_half;
        default: w_next_blank = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_state <= EXPIRED;
      r_blank <= 1'b0;
    end else begin
      r_count <= w_next;
      r_state <= w_next_state;
      r_blank <= w_next_blank;
    end
  end

  assign BCOUNT   = r_count;
  assign tick_1hz = w_tick;
  assign blank    = r_blank;
  assign state_o  = r_state;

`ifdef METER_BCD_OUT_EN
  logic [15:0] r_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= 16'h0000;
    end else begin
      r_bcd <= meter_pkg::bin_to_bcd(14'(r_count));
    end
  end

  assign bcd_o = r_bcd;
`endif

endmodule

// File: tb/tb_meter_ctrl.sv
// Scoreboard bench for meter_ctrl at CLK_HZ=8 (tick every 8 cycles, half pulse every 4).
`timescale 1ns/1ps
module tb_meter_ctrl;

  localparam int CLK_HZ = 8;
  localparam int CNT_W  = 14;
  localparam int W      = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             add_50 = 1'b0, add_150 = 1'b0, add_200 = 1'b0, add_500 = 1'b0;
  logic             set_10 = 1'b0, set_205 = 1'b0;
  logic [CNT_W-1:0] BCOUNT;
  logic             tick_1hz;
  logic             blank;
  logic [1:0]       state_o;
`ifdef METER_BCD_OUT_EN
  logic [15:0]      bcd_o;
`endif

  always #5 clk = ~clk;

  meter_ctrl #(
    .CLK_HZ(CLK_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_50  (add_50),
    .add_150 (add_150),
    .add_200 (add_200),
    .add_500 (add_500),
    .set_10  (set_10),
    .set_205 (set_205),
    .BCOUNT  (BCOUNT),
    .tick_1hz(tick_1hz),
    .blank   (blank),
    .state_o (state_o)
`ifdef METER_BCD_OUT_EN
    ,
    .bcd_o   (bcd_o)
`endif
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: count, state code (0 expired, 1 low, 2 high), blank, cycle index.
  int m_count = 0;
  int m_state = 0;
  int m_blank = 0;
  int m_k     = 0;
  int m_prev  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int state_of(input int c);
    if (c == 0) return 0;
    if (c < 200) return 1;
    return 2;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_state = 0;
    m_blank = 0;
    m_k     = 0;
    m_prev  = 0;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_BCOUNT"}, BCOUNT, 0);
    chk({tag, "_tick"}, tick_1hz, 0);
    chk({tag, "_blank"}, blank, 0);
    chk({tag, "_state"}, state_o, 0);
`ifdef METER_BCD_OUT_EN
    chk({tag, "_bcd"}, bcd_o, 0);
`endif
  endtask

  // b = {set_205, set_10, add_500, add_200, add_150, add_50}; called at a negedge.
  task automatic step(input logic [5:0] b);
    int amt, nxt, ns, nb;
    bit tk, hf, tk_next;
    logic [W-1:0] e;
    {set_205, set_10, add_500, add_200, add_150, add_50} = b;
    tk  = (m_k > 0) && (m_k % 8 == 0);
    hf  = (m_k > 0) && (m_k % 4 == 0);
    amt = b[3] ? 500 : b[2] ? 200 : b[1] ? 150 : b[0] ? 50 : 0;
    if (b[5]) nxt = 205;
    else if (b[4]) nxt = 10;
    else if (amt != 0) begin
      nxt = m_count + amt - ((tk && m_count > 0) ? 1 : 0);
      if (nxt > 9999) nxt = 9999;
    end else nxt = (tk && m_count > 0) ? m_count - 1 : m_count;
    ns = state_of(nxt);
    if (ns != m_state || ns == 2) nb = 0;
    else if (ns == 1) nb = tk ? 1 - m_blank : m_blank;
    else nb = hf ? 1 - m_blank : m_blank;
    m_count = nxt;
    m_state = ns;
    m_blank = nb;
    m_k++;
    tk_next = (m_k % 8 == 0);
    e = {14'(nxt), tk_next, nb[0], ns[1:0]};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'b000000);
  endtask

  task automatic align_tick();
    for (int i = 0; i < 16 && !((m_k > 0) && (m_k % 8 == 0)); i++) step(6'b000000);
  endtask

  // Monitor: outputs settle after every active edge; compare against the oldest expectation.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("BCOUNT", BCOUNT, e[17:4]);
        chk("tick_1hz", tick_1hz, e[3]);
        chk("blank", blank, e[2]);
        chk("state", state_o, e[1:0]);
`ifdef METER_BCD_OUT_EN
        chk("bcd_o", bcd_o, to_bcd(m_prev));
        m_prev = e[17:4];
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] b;
    int r;
    #3 rst_n = 1'b0;
    #1 rst_chk("por");
    repeat (3) @(negedge clk);
    rst_chk("por_hold");
    model_reset();
    rst_n = 1'b1;

    idle(40);
    step(6'b100000);
    idle(60);
    step(6'b010000);
    idle(100);

    repeat (20) step(6'b001000);
    align_tick();
    step(6'b000001);
    idle(3);

    step(6'b010000);
    idle(100);
    step(6'b000011);
    align_tick();
    step(6'b000100);
    idle(5);

    step(6'b010000);
    idle(100);
    step(6'b101000);
    idle(2);
    step(6'b000001);
    step(6'b000001);
    idle(3);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_chk("async");
    @(negedge clk);
    rst_chk("async_hold");
    model_reset();
    rst_n = 1'b1;

    repeat (600) begin
      r = $urandom_range(0, 99);
      b = 6'b000000;
      if (r < 2) b = {2'b10, 4'($urandom_range(0, 15))};
      else if (r < 4) b = {2'b01, 4'($urandom_range(0, 15))};
      else if (r < 10) b = {2'b00, 4'($urandom_range(1, 15))};
      step(b);
    end
    idle(10);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/meter_ctrl.md
Name: meter_ctrl

Overview:
Sequencing controller for the parking-meter countdown datapath. It owns the 14-bit remaining-time count and applies the following updates: coin additions, preset loads, and the once-per-second decrement. It also derives the display flash/blank control from the count value. It sits between the debounced button pulses and the display/seven-segment driver.

Parameters:
CLK_HZ, 100_000_000, input clock frequency; sets the half-second tick divider (CLK_HZ/2 cycles).
CNT_W, 14, count width.
MAX_COUNT, 9999, saturation ceiling for additions.
LOW_THRESH, 200, count below which the display flashes slowly.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
add_50  in  1  single-cycle pulse, add 50 s
add_150  in  1  single-cycle pulse, add 150 s
add_200  in  1  single-cycle pulse, add 200 s
add_500  in  1  single-cycle pulse, add 500 s
set_10  in  1  single-cycle pulse, load 10
set_205  in  1  single-cycle pulse, load 205
BCOUNT  out  14  registered remaining time, 0..MAX_COUNT
tick_1hz  out  1  one-cycle pulse on each decrement opportunity
blank  out  1  1 = display off (flash phase)
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): BCOUNT=0, tick_1hz=0, blank=0, divider=0, half-phase=0, state=EXPIRED.
- Divider: half-second pulse every CLK_HZ/2 cycles. A phase bit alternates on each pulse. tick_1hz fires on every second half-pulse (phase 1→0), so it repeats every CLK_HZ cycles. The divider free-runs; adds and sets never restart it.
- Update priority in a cycle, with the result registered the next clock (latency 1):
  - 1. set_205 → 205
  - 2. set_10 → 10
  - 3. Highest asserted add (add_500 > add_200 > add_150 > add_50). Only one amount applies per cycle.
  - 4. No button → decrement only.
- Decrement: on tick_1hz, count-1 if count>0; at 0 it stays 0.
- Add and tick in the same cycle: count + amt − 1, then saturate to MAX_COUNT. At count=0 there is no −1: the result is amt.
- Set and tick in the same cycle: the set wins, and there is no decrement that cycle.
- Saturation: compute in CNT_W+1 bits; any result >MAX_COUNT clamps to MAX_COUNT.
- FSM, evaluated on the next-count value:
  - EXPIRED (count==0)
  - LOW (0<count<LOW_THRESH)
  - HIGH (count≥LOW_THRESH)
  - Transitions are immediate, from the registered next count.
- blank:
  - HIGH: blank=0.
  - LOW: blank toggles on each tick_1hz (1 s on / 1 s off), and is forced to 0 on entry to LOW.
  - EXPIRED: blank toggles on every half-second pulse (0.5 s on/off), and is forced to 0 on entry to EXPIRED.
- Reset mid-operation: everything returns to reset values immediately; no pending update survives.
- BCOUNT is output-only in this block. The standalone decrementer arithmetic is absorbed here.

Optional Feature:
METER_BCD_OUT_EN
- Defined: adds output port bcd_o[15:0], four BCD digits of BCOUNT. It uses a registered double-dabble converter, one clock behind BCOUNT, with reset value 16'h0000.
- Undefined: no port and no converter logic; the display driver performs its own conversion.

Decomposition:
- meter_pkg holds:
  - constants MAX_COUNT, LOW_THRESH, ADD_50/150/200/500, PRESET_10/205
  - enum meter_state_t {EXPIRED, LOW, HIGH}
- Sub-module meter_tick_gen (parameter CLK_HZ; ports clk, rst_n, half_pulse, tick_1hz) holds the divider and phase bit.

Test Plan:
- All six scenarios run with CLK_HZ=8, so tick_1hz repeats every 8 cycles.
- Reset then idle 40 cycles → BCOUNT=0, state EXPIRED, blank toggles every 4 cycles.
- set_205 pulse → BCOUNT=205 next clock, state HIGH, blank=0. Over the following 6 ticks BCOUNT reaches 199: state LOW, blank starts at 0 and toggles every tick.
- set_10 then 10 ticks → BCOUNT reaches 0 and holds 0 on further ticks; state EXPIRED.
- BCOUNT=9800, add_500 → 9999 (saturated). A further add_50 coinciding with tick_1hz → 9999.
- add_150 and add_50 in the same cycle from 0 → 150. Then add_200 coincident with tick → 349.
- set_205 and add_500 together at BCOUNT=0 → 205. Assert rst_n=0 mid-count at 300 → BCOUNT=0 asynchronously, blank=0.
